// File: rtl/tl45_fetch.sv
// tl45 instruction-fetch stage: owns the PC and issues one pipelined Wishbone read at a time.
// Optional TL45_FETCH_ALIGN_CHECK_EN turns a misaligned flush target into a fetch fault.
module tl45_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_pipe_stall,
  input  logic        i_pipe_flush,
  input  logic [31:0] i_flush_pc,
  output logic        o_wb_cyc,
  output logic        o_wb_stb,
  output logic [29:0] o_wb_addr,
  input  logic        i_wb_stall,
  input  logic        i_wb_ack,
  input  logic        i_wb_err,
  input  logic [31:0] i_wb_data,
  output logic [31:0] o_buf_pc,
  output logic [31:0] o_buf_inst,
  output logic        o_fetch_err
);

  localparam logic [1:0] S_REQ  = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;
  localparam logic [1:0] S_ERR  = 2'd3;

  logic [1:0]  state_q,      state_d;
  logic [31:0] pc_q,         pc_d;
  logic        cyc_q,        cyc_d;
  logic        stb_q,        stb_d;
  logic        skid_valid_q, skid_valid_d;
  logic [31:0] skid_pc_q,    skid_pc_d;
  logic [31:0] skid_inst_q,  skid_inst_d;
  logic [31:0] buf_pc_q,     buf_pc_d;
  logic [31:0] buf_inst_q,   buf_inst_d;
  logic        err_q,        err_d;

  always_comb begin
    // NOTE: every next-state signal starts from its current value so no path leaves it unassigned (no latches).
    state_d      = state_q;
    pc_d         = pc_q;
    cyc_d        = cyc_q;
    stb_d        = stb_q;
    skid_valid_d = skid_valid_q;
    skid_pc_d    = skid_pc_q;
    skid_inst_d  = skid_inst_q;
    buf_pc_d     = buf_pc_q;
    buf_inst_d   = buf_inst_q;
    err_d        = err_q;

    // Output slot drains every unstalled edge: skid first, otherwise a bubble unless a word is acked below.
    if (!i_pipe_stall) begin
      if (skid_valid_q) begin
        buf_pc_d     = skid_pc_q;
        buf_inst_d   = skid_inst_q;
        skid_valid_d = 1'b0;
      end else begin
        buf_pc_d   = 32'h0;
        buf_inst_d = 32'h0;
      end
    end

    case (state_q)
      S_REQ: begin
        if (!stb_q) begin
          cyc_d = 1'b1;
          stb_d = 1'b1;
        end else if (!i_wb_stall) begin
          stb_d   = 1'b0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (i_wb_err) begin
          cyc_d   = 1'b0;
          err_d   = 1'b1;
          state_d = S_ERR;
        end else if (i_wb_ack) begin
          cyc_d = 1'b0;
          pc_d  = pc_q + 32'd4;
          if (!i_pipe_stall && !skid_valid_q) begin
            buf_pc_d   = pc_q;
            buf_inst_d = i_wb_data;
            state_d    = S_REQ;
          end else begin
            skid_valid_d = 1'b1;
            skid_pc_d    = pc_q;
            skid_inst_d  = i_wb_data;
            state_d      = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (!i_pipe_stall) state_d = S_REQ;
      end
      default: ;
    endcase

    // Redirect wins over everything above; any ack/err seen this cycle is dropped.
    if (i_pipe_flush) begin
      pc_d         = i_flush_pc & 32'hFFFF_FFFC;
      skid_valid_d = 1'b0;
      buf_pc_d     = 32'h0;
      buf_inst_d   = 32'h0;
      cyc_d        = 1'b0;
      stb_d        = 1'b0;
      err_d        = 1'b0;
      state_d      = S_REQ;
`ifdef TL45_FETCH_ALIGN_CHECK_EN
      if (|i_flush_pc[1:0]) begin
        err_d   = 1'b1;
        state_d = S_ERR;
      end
`endif
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q      <= S_REQ;
      pc_q         <= RESET_PC;
      cyc_q        <= 1'b0;
      stb_q        <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_pc_q    <= 32'h0;
      skid_inst_q  <= 32'h0;
      buf_pc_q     <= 32'h0;
      buf_inst_q   <= 32'h0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      cyc_q        <= cyc_d;
      stb_q        <= stb_d;
      skid_valid_q <= skid_valid_d;
      skid_pc_q    <= skid_pc_d;
      skid_inst_q  <= skid_inst_d;
      buf_pc_q     <= buf_pc_d;
      buf_inst_q   <= buf_inst_d;
      err_q        <= err_d;
    end
  end

  assign o_wb_cyc    = cyc_q;
  assign o_wb_stb    = stb_q;
  assign o_wb_addr   = pc_q[31:2];
  assign o_buf_pc    = buf_pc_q;
  assign o_buf_inst  = buf_inst_q;
  assign o_fetch_err = err_q;

endmodule

// File: tb/tb_tl45_fetch.sv
// Self-checking bench for tl45_fetch: Wishbone slave model plus a queue of expected fetched words.
module tb_tl45_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        i_clk = 1'b0;
  logic        i_reset, i_pipe_stall, i_pipe_flush;
  logic [31:0] i_flush_pc;
  logic        o_wb_cyc, o_wb_stb;
  logic [29:0] o_wb_addr;
  logic        i_wb_stall, i_wb_ack, i_wb_err;
  logic [31:0] i_wb_data;
  logic [31:0] o_buf_pc, o_buf_inst;
  logic        o_fetch_err;

  tl45_fetch #(.RESET_PC(RESET_PC)) dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_pipe_stall(i_pipe_stall), .i_pipe_flush(i_pipe_flush), .i_flush_pc(i_flush_pc),
    .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_addr(o_wb_addr),
    .i_wb_stall(i_wb_stall), .i_wb_ack(i_wb_ack), .i_wb_err(i_wb_err), .i_wb_data(i_wb_data),
    .o_buf_pc(o_buf_pc), .o_buf_inst(o_buf_inst), .o_fetch_err(o_fetch_err)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } word_t;

  word_t       exp_q[$];
  word_t       last_exp;
  int          n_checks = 0, n_fail = 0;
  int          stall_cnt = 0, stb_cycles = 0, acc_cnt = 0, pop_cnt = 0;
  int          tcount = 0, last_pop_t = 0, prev_pop_t = 0;
  bit          err_en = 0, pend = 0, exp_err = 0;
  logic [29:0] err_addr = '0, pend_addr = '0, exp_addr = '0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // One clock: slave response set up at the falling edge, bookkeeping after the rising edge,
  // output checks at the next falling edge.
  task automatic tick();
    bit          accept, ack_now, err_now, rst_e, stl_e, fl_e;
    logic [29:0] addr_now;
    logic [31:0] fpc;
    word_t       e;
    i_wb_ack = 1'b0; i_wb_err = 1'b0; i_wb_data = 32'h0; i_wb_stall = 1'b0;
    ack_now = 0; err_now = 0;
    if (pend) begin
      if (err_en && pend_addr == err_addr) begin
        i_wb_err = 1'b1; err_now = 1;
      end else begin
        i_wb_ack  = 1'b1; ack_now = 1;
        i_wb_data = {2'b00, pend_addr} ^ 32'hA5A5_0000;
      end
    end
    if (o_wb_cyc === 1'b1 && o_wb_stb === 1'b1) begin
      stb_cycles++;
      if (stall_cnt > 0) begin
        i_wb_stall = 1'b1;
        stall_cnt--;
      end
    end
    accept   = (o_wb_cyc === 1'b1) && (o_wb_stb === 1'b1) && !i_wb_stall && !i_pipe_flush && !i_reset;
    addr_now = o_wb_addr;
    rst_e    = i_reset;
    stl_e    = i_pipe_stall;
    fl_e     = i_pipe_flush;
    fpc      = i_flush_pc;

    @(posedge i_clk);
    tcount++;
    if (rst_e) begin
      pend = 0; exp_q.delete(); exp_err = 0; exp_addr = RESET_PC[31:2];
    end else if (fl_e) begin
      pend = 0; exp_q.delete(); exp_addr = fpc[31:2];
`ifdef TL45_FETCH_ALIGN_CHECK_EN
      exp_err = |fpc[1:0];
`else
      exp_err = 0;
`endif
    end else begin
      if (ack_now) exp_q.push_back('{pc: {pend_addr, 2'b00}, inst: i_wb_data});
      if (ack_now || err_now) pend = 0;
      if (err_now) exp_err = 1;
      if (accept) begin
        check("wb_addr", {2'b00, addr_now}, {2'b00, exp_addr});
        exp_addr++;
        acc_cnt++;
        pend      = 1;
        pend_addr = addr_now;
      end
    end

    @(negedge i_clk);
    if (rst_e || fl_e) begin
      check("clr_buf_pc", o_buf_pc, 32'h0);
      check("clr_buf_inst", o_buf_inst, 32'h0);
      check("clr_cyc", {31'h0, o_wb_cyc}, 32'h0);
      check("clr_stb", {31'h0, o_wb_stb}, 32'h0);
      last_exp = '0;
    end else if (stl_e) begin
      check("hold_pc", o_buf_pc, last_exp.pc);
      check("hold_inst", o_buf_inst, last_exp.inst);
    end else if (o_buf_inst != 32'h0) begin
      if (exp_q.size() == 0) begin
        check("unexpected_inst", o_buf_inst, 32'h0);
      end else begin
        e = exp_q.pop_front();
        check("buf_pc", o_buf_pc, e.pc);
        check("buf_inst", o_buf_inst, e.inst);
        last_exp   = e;
        pop_cnt++;
        prev_pop_t = last_pop_t;
        last_pop_t = tcount;
      end
    end else begin
      check("bubble_pc", o_buf_pc, 32'h0);
      last_exp = '0;
    end
    check("fetch_err", {31'h0, o_fetch_err}, {31'h0, exp_err});
  endtask

  task automatic do_flush(input logic [31:0] pc);
    i_pipe_flush = 1'b1;
    i_flush_pc   = pc;
    tick();
    i_pipe_flush = 1'b0;
  endtask

  initial begin
    int acc0;
    i_reset = 1'b1; i_pipe_stall = 1'b0; i_pipe_flush = 1'b0; i_flush_pc = 32'h0;
    i_wb_stall = 1'b0; i_wb_ack = 1'b0; i_wb_err = 1'b0; i_wb_data = 32'h0;
    stall_cnt = 3;
    tick();
    tick();
    i_reset = 1'b0;

    // First request held off by the slave for three cycles.
    for (int i = 0; i < 20 && acc_cnt == 0; i++) tick();
    check("first_accept", acc_cnt, 1);
    check("stb_hold_cycles", stb_cycles, 4);

    // Streaming with a zero-wait slave.
    for (int i = 0; i < 30 && pop_cnt < 2; i++) tick();
    check("pops_stream", pop_cnt, 2);
    check("throughput", last_pop_t - prev_pop_t, 3);

    // Stall decode across the ack of the word at pc 8.
    for (int i = 0; i < 30 && !(pend && pend_addr == 30'd2); i++) tick();
    check("reach_word2", {31'h0, pend}, 32'h1);
    i_pipe_stall = 1'b1;
    repeat (5) begin
      tick();
      check("hold_no_stb", {31'h0, o_wb_stb}, 32'h0);
    end
    i_pipe_stall = 1'b0;
    tick();
    check("skid_out_pc", o_buf_pc, 32'h8);
    for (int i = 0; i < 20 && acc_cnt < 4; i++) tick();
    check("accept_after_skid", acc_cnt, 4);

    // Flush while the ack for addr 3 arrives: the word must be dropped.
    check("flush_in_wait", {31'h0, pend}, 32'h1);
    do_flush(32'h0000_0100);
    for (int i = 0; i < 30 && pop_cnt < 4; i++) tick();
    check("post_flush_pc", o_buf_pc, 32'h100);

    // Bus error on pc 4, then recover with a flush to 0.
    err_en = 1; err_addr = 30'd1;
    do_flush(32'h0);
    for (int i = 0; i < 30 && !exp_err; i++) tick();
    check("err_pops", pop_cnt, 5);
    check("err_flag", {31'h0, o_fetch_err}, 32'h1);
    repeat (6) begin
      tick();
      check("err_no_cyc", {31'h0, o_wb_cyc}, 32'h0);
    end
    err_en = 0;
    do_flush(32'h0);
    for (int i = 0; i < 30 && pop_cnt < 7; i++) tick();
    check("refetch_pc", o_buf_pc, 32'h4);

    // Misaligned redirect.
    do_flush(32'h0000_0102);
`ifdef TL45_FETCH_ALIGN_CHECK_EN
    acc0 = acc_cnt;
    repeat (6) tick();
    check("misalign_no_accept", acc_cnt, acc0);
    check("misalign_err", {31'h0, o_fetch_err}, 32'h1);
`else
    acc0 = pop_cnt;
    for (int i = 0; i < 30 && pop_cnt == acc0; i++) tick();
    check("misalign_fetch_pc", o_buf_pc, 32'h100);
`endif
    check("queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
